// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//   Watches the multiplexed, active-low seven-segment bus driven by the display
//   path. It decodes each stable segment pattern back to a 4-bit digit and keeps
//   one decoded value per anode position. The top level and benches use it to
//   read back what is actually on the pins.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_seg[7:0]     segment bus, active-low (bit7 = dp, bits6:0 = g..a)
//   i_an[3:0]      anode bus, active-low, exactly one zero when valid
//   o_digits[15:0] decoded values; nibble k belongs to anode k
//   o_dp[3:0]      decimal point lit at the last capture, per position
//   o_blank[3:0]   position captured with all segments off
//   o_err          sticky flag for any undecodable capture
//   o_frame_done   one-cycle pulse when all four positions have been captured
//
// Timing: pin change -> o_digits updated = 1 + STABLE_CYCLES + 1 cycles.
// There is no handshake. Every output is a level register, except
// o_frame_done, which is a single-cycle pulse.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_seg,
  input  logic [3:0]  i_an,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_err,
  output logic        o_frame_done
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // Sample layout: {an[3:0], seg[7:0]}
  logic [11:0] r_sample;
  logic [11:0] r_prev;
  logic [7:0]  r_cnt;
  logic        r_captured;
  logic [3:0]  r_seen;
  logic [15:0] r_digits;
  logic [3:0]  r_dp;
  logic [3:0]  r_blank;
  logic        r_err;
  logic        r_frame_done;

  logic [3:0]  w_an_n;
  logic        w_valid;
  logic        w_same;
  logic        w_capture;
  logic [3:0]  w_pos_mask;
  logic [3:0]  w_digit;
  logic        w_is_blank;
  logic        w_is_bad;
  logic [3:0]  w_seen_nxt;

  // Valid means the inverted anode bus is one-hot.
  assign w_an_n  = ~r_sample[11:8];
  assign w_valid = (w_an_n != 4'h0) && ((w_an_n & (w_an_n - 4'h1)) == 4'h0);
  assign w_same  = (r_sample == r_prev);

  // r_cnt describes the run that ends in r_prev. A nonzero count implies that
  // r_prev was a valid sample. The capture therefore decodes r_prev, whatever
  // the newest sample holds.
  assign w_capture  = (r_cnt == STABLE_MAX) && !r_captured;
  assign w_pos_mask = ~r_prev[11:8];
  assign w_seen_nxt = r_seen | w_pos_mask;

  // The decode uses seg[6:0] with dp ignored, and needs an exact match.
  always_comb begin
    w_digit    = 4'hE;
    w_is_blank = 1'b0;
    w_is_bad   = 1'b0;
    case (r_prev[6:0])
      7'h40: w_digit = 4'h0;
      7'h79: w_digit = 4'h1;
      7'h24: w_digit = 4'h2;
      7'h30: w_digit = 4'h3;
      7'h19: w_digit = 4'h4;
      7'h12: w_digit = 4'h5;
      7'h02: w_digit = 4'h6;
      7'h78: w_digit = 4'h7;
      7'h00: w_digit = 4'h8;
      7'h10: w_digit = 4'h9;
      7'h7F: begin
        w_digit    = 4'hF;
        w_is_blank = 1'b1;
      end
      default: begin
        w_digit  = 4'hE;
        w_is_bad = 1'b1;
      end
    endcase
  end

  // Input register, stability counter and the once-per-run capture flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample   <= 12'hFFF;
      r_prev     <= 12'hFFF;
      r_cnt      <= 8'd0;
      r_captured <= 1'b0;
    end else begin
      r_sample <= {i_an, i_seg};
      r_prev   <= r_sample;
      if (!w_valid) begin
        r_cnt      <= 8'd0;
        r_captured <= 1'b0;
      end else if (w_same) begin
        if (r_cnt != STABLE_MAX) begin
          r_cnt <= r_cnt + 8'd1;
        end
        r_captured <= r_captured | w_capture;
      end else begin
        r_cnt      <= 8'd1;
        r_captured <= 1'b0;
      end
    end
  end

  // Per-position result registers and frame tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digits     <= 16'h0000;
      r_dp         <= 4'h0;
      r_blank      <= 4'hF;
      r_err        <= 1'b0;
      r_seen       <= 4'b0000;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_capture) begin
        for (int k = 0; k < 4; k++) begin
          if (w_pos_mask[k]) begin
            r_digits[4*k +: 4] <= w_digit;
            r_dp[k]            <= ~r_prev[7];
            r_blank[k]         <= w_is_blank;
          end
        end
        if (w_is_bad) begin
          r_err <= 1'b1;
        end
        // The capture that completes a frame does not carry into the next one.
        if (w_seen_nxt == 4'b1111) begin
          r_seen       <= 4'b0000;
          r_frame_done <= 1'b1;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

  assign o_digits     = r_digits;
  assign o_dp         = r_dp;
  assign o_blank      = r_blank;
  assign o_err        = r_err;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's seven-segment encoder and anode driver.
- Samples the multiplexed, active-low seg/an bus and decodes each stable segment pattern back to a 4-bit digit. Stores one value per anode position.
- Used as an on-chip monitor and self-check for the stopwatch display path, so benches and the top level can read back what is actually being driven.

Parameters:
- STABLE_CYCLES, 4, consecutive identical {an,seg} samples required before a capture; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg  input  8  segment bus, active-low; bit7 = dp, bits6:0 = g..a. Synchronous to clk.
- an  input  4  anode bus, active-low, one-hot-zero when valid. Synchronous to clk.
- digits  output  16  decoded values; digits[4k+3:4k] belongs to anode k (an[k]=0).
- dp  output  4  decimal point lit (seg[7]=0) at last capture, per position.
- blank  output  4  position captured all-off (seg[6:0]=7'h7F).
- err  output  1  sticky: set when any capture was an undecodable pattern.
- frame_done  output  1  one-cycle pulse when all four positions have captured since the last pulse.

Behaviour:
- Reset (async, immediate):
  - digits=16'h0000, dp=4'h0, blank=4'hF, err=0, frame_done=0.
  - Internal: stability counter=0, previous-sample register=12'hFFF, seen=4'b0000, captured flag=0.
- Input register: seg/an are registered once. All decisions use the registered sample and the previous registered sample.
- Anode validity: a sample is valid only when an has exactly one 0 bit.
  - Invalid values are 4'hF (all off), 4'h0, or multiple zeros.
  - An invalid sample resets the counter to 0, clears the captured flag, and never captures.
- Stability counter:
  - If the current valid sample equals the previous sample, increment, saturating at STABLE_CYCLES.
  - Otherwise load 1 and clear the captured flag.
- Capture fires on the cycle the counter reaches STABLE_CYCLES with the captured flag clear. It then sets the captured flag.
  - Exactly one capture per stable run; a run held for 1000 cycles captures once.
  - With STABLE_CYCLES=1, every valid change captures on its first cycle.
- Decode of seg[6:0], dp ignored. Exact match only:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
  - 7F -> blank: digit value 4'hF, blank bit set, err unaffected.
  - Any other pattern -> digit value 4'hE, blank bit cleared, err set.
- Capture update, registered (visible the cycle after the capture condition):
  - Update the selected position's digits nibble, dp bit and blank bit; set seen[k].
  - Other positions hold.
- Latency: pin change to digits updated = 1 (input reg) + STABLE_CYCLES + 1 cycles. Default is 6 cycles.
- Frame:
  - When a capture makes seen==4'b1111, frame_done=1 on the next cycle and seen clears to 0 in that same update.
  - Recapturing an already-seen position does not advance the frame.
  - A capture that completes a frame also counts as the completing update; seen does not retain that bit for the new frame.
- err clears only on rst.
- Reset mid-run: all state clears at once; the first capture after release again needs STABLE_CYCLES matching samples.
- No handshake: outputs are level registers, except frame_done, which is a pulse.

Test Plan:
- Reset: assert rst mid-capture run -> all outputs at reset values within the same cycle; counter restarts after release.
- Single digit: an=4'b1110, seg=8'hC0 held 10 cycles -> digits[3:0]=0 at cycle 6, exactly one update, dp[0]=0, blank[0]=0.
- Full frame: cycle an 1110/1101/1011/0111 with seg A4/B0/99/92, 8 cycles each -> digits=16'h5432, one frame_done pulse after the 4th capture, seen back to 0.
- Stability filter: toggle seg between C0 and F9 every 2 cycles on an=1110 for 20 cycles -> no capture, digits unchanged. Then hold F9 -> digits[3:0]=1.
- Invalid inputs: an=4'b1100 with seg=C0 for 10 cycles -> no capture. Then an=1110, seg=8'h55 stable -> digits[3:0]=E, err=1 and stays 1. Then seg=8'hFF -> nibble F, blank[0]=1.
- Decimal point: an=1101, seg=8'h40 (0 with dp) stable -> digits[7:4]=0, dp[1]=1.
